// File: rtl/rsa_decrypt_engine.sv
// Sequential RSA decryption core: Plaintext = Ciphertext^PrivExp mod Modulus.
// Optional macro CONST_TIME_EN makes the multiply step run for every exponent bit.
module rsa_decrypt_engine #(
    parameter int WIDTH = 8,
    parameter int EXP_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Ciphertext,
    input  logic [EXP_W-1:0] PrivExp,
    input  logic [WIDTH-1:0] Modulus,
    output logic [WIDTH-1:0] Plaintext,
    output logic             Busy,
    output logic             Valid,
    output logic             Error
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REDUCE = 2'd1;
    localparam logic [1:0] ST_SQR    = 2'd2;
    localparam logic [1:0] ST_MUL    = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] c_reg;
    logic [EXP_W-1:0] d_reg;
    logic [WIDTH-1:0] n_reg;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] cr;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    logic [WIDTH:0]   n_ext;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH:0]   dbl;
    logic [WIDTH:0]   dbl_red;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] acc_next;
    logic             mul_bit;
    logic             d_bit;
    logic             last_bit;
    logic             last_exp;
    logic             do_mul;
    logic             commit;
    logic [WIDTH-1:0] mul_result;

    // One iteration of the restoring remainder and of the interleaved modular multiplier.
    // SQR uses R as both operands; MUL scans cr as multiplier bits against R.
    always_comb begin
        n_ext     = {1'b0, n_reg};
        rem_shift = {rem, c_reg[cnt]};
        rem_next  = (rem_shift >= n_ext) ? WIDTH'(rem_shift - n_ext) : rem_shift[WIDTH-1:0];

        mul_bit = (state == ST_SQR) ? r[cnt] : cr[cnt];
        dbl     = {acc, 1'b0};
        dbl_red = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
        sum     = mul_bit ? (dbl_red + {1'b0, r}) : dbl_red;
        acc_next = (sum >= n_ext) ? WIDTH'(sum - n_ext) : sum[WIDTH-1:0];

        d_bit    = d_reg[idx];
        last_bit = (cnt == '0);
        last_exp = (idx == '0);
`ifdef CONST_TIME_EN
        do_mul = 1'b1;
        commit = d_bit;
`else
        do_mul = d_bit;
        commit = 1'b1;
`endif
        mul_result = commit ? acc_next : r;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            c_reg     <= '0;
            d_reg     <= '0;
            n_reg     <= '0;
            rem       <= '0;
            cr        <= '0;
            r         <= '0;
            acc       <= '0;
            cnt       <= '0;
            idx       <= '0;
            Plaintext <= '0;
            Busy      <= 1'b0;
            Valid     <= 1'b0;
            Error     <= 1'b0;
        end else begin
            Valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        c_reg <= Ciphertext;
                        d_reg <= PrivExp;
                        n_reg <= Modulus;
                        if (Modulus < WIDTH'(2)) begin
                            Plaintext <= '0;
                            Error     <= 1'b1;
                            Valid     <= 1'b1;
                        end else begin
                            Error <= 1'b0;
                            Busy  <= 1'b1;
                            rem   <= '0;
                            cnt   <= CNT_W'(WIDTH - 1);
                            state <= ST_REDUCE;
                        end
                    end
                end
                ST_REDUCE: begin
                    rem <= rem_next;
                    cnt <= cnt - 1'b1;
                    if (last_bit) begin
                        cr    <= rem_next;
                        r     <= WIDTH'(1);
                        acc   <= '0;
                        cnt   <= CNT_W'(WIDTH - 1);
                        idx   <= IDX_W'(EXP_W - 1);
                        state <= ST_SQR;
                    end
                end
                ST_SQR: begin
                    acc <= acc_next;
                    cnt <= cnt - 1'b1;
                    if (last_bit) begin
                        r   <= acc_next;
                        acc <= '0;
                        cnt <= CNT_W'(WIDTH - 1);
                        if (do_mul) begin
                            state <= ST_MUL;
                        end else if (last_exp) begin
                            Plaintext <= acc_next;
                            Valid     <= 1'b1;
                            Busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    acc <= acc_next;
                    cnt <= cnt - 1'b1;
                    if (last_bit) begin
                        // In constant-time builds the product is computed but dropped for zero bits.
                        r   <= mul_result;
                        acc <= '0;
                        cnt <= CNT_W'(WIDTH - 1);
                        if (last_exp) begin
                            Plaintext <= mul_result;
                            Valid     <= 1'b1;
                            Busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            idx   <= idx - 1'b1;
                            state <= ST_SQR;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_decrypt_engine.sv
// Self-checking bench for rsa_decrypt_engine: directed cases plus randomized
// jobs compared against a plain-arithmetic modular exponentiation model.
module tb_rsa_decrypt_engine;

    localparam int WIDTH = 8;
    localparam int EXP_W = 8;

    logic             Clk;
    logic             Reset;
    logic             Start;
    logic [WIDTH-1:0] Ciphertext;
    logic [EXP_W-1:0] PrivExp;
    logic [WIDTH-1:0] Modulus;
    logic [WIDTH-1:0] Plaintext;
    logic             Busy;
    logic             Valid;
    logic             Error;

    int errors = 0;
    int checks = 0;

    rsa_decrypt_engine #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .Ciphertext(Ciphertext),
        .PrivExp(PrivExp),
        .Modulus(Modulus),
        .Plaintext(Plaintext),
        .Busy(Busy),
        .Valid(Valid),
        .Error(Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: c^d mod n by plain integer arithmetic over the exponent bits.
    function automatic int model_pow(int c, int d, int n);
        longint res = 1;
        longint base = c % n;
        for (int i = EXP_W - 1; i >= 0; i--) begin
            res = (res * res) % n;
            if (((d >> i) & 1) == 1) res = (res * base) % n;
        end
        return int'(res);
    endfunction

    function automatic int model_latency(int d);
        int pc = 0;
        for (int i = 0; i < EXP_W; i++) pc += (d >> i) & 1;
`ifdef CONST_TIME_EN
        return WIDTH * (1 + 2 * EXP_W);
`else
        return WIDTH * (1 + EXP_W + pc);
`endif
    endfunction

    // Drives one request; called between clock edges, returns #1 after the Valid edge.
    task automatic run_job(input int c, input int d, input int n,
                           output int m, output int err, output int lat, output int busy_after);
        Ciphertext = WIDTH'(c);
        PrivExp    = EXP_W'(d);
        Modulus    = WIDTH'(n);
        Start      = 1'b1;
        @(posedge Clk);
        #1;
        Start      = 1'b0;
        busy_after = int'(Busy);
        lat = 0;
        while (!Valid && lat < 400) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        if (!Valid) lat = -1;
        m   = int'(Plaintext);
        err = int'(Error);
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        Start = 1'b0;
        Ciphertext = '0;
        PrivExp = '0;
        Modulus = '0;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if ({Plaintext, Busy, Valid, Error} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got pt=%0d busy=%0b valid=%0b err=%0b want all 0",
                     Plaintext, Busy, Valid, Error);
        end
        Reset = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_directed;
        int m, err, lat, busy;
        int cases[5][3] = '{'{31, 7, 33}, '{11, 23, 187}, '{200, 1, 33}, '{5, 0, 33}, '{66, 5, 33}};
        for (int k = 0; k < 5; k++) begin
            run_job(cases[k][0], cases[k][1], cases[k][2], m, err, lat, busy);
            checks++;
            if (busy !== 1) begin
                errors++;
                $display("[TB] FAIL dir%0d_busy got %0d want 1", k, busy);
            end
            checks++;
            if (m !== model_pow(cases[k][0], cases[k][1], cases[k][2]) || err !== 0) begin
                errors++;
                $display("[TB] FAIL dir%0d_result got pt=%0d err=%0d want pt=%0d err=0",
                         k, m, err, model_pow(cases[k][0], cases[k][1], cases[k][2]));
            end
            checks++;
            if (lat !== model_latency(cases[k][1])) begin
                errors++;
                $display("[TB] FAIL dir%0d_latency got %0d want %0d", k, lat, model_latency(cases[k][1]));
            end
            @(posedge Clk);
            #1;
            checks++;
            if (Valid !== 1'b0 || Busy !== 1'b0 || int'(Plaintext) !== m) begin
                errors++;
                $display("[TB] FAIL dir%0d_pulse got valid=%0b busy=%0b pt=%0d want 0 0 %0d",
                         k, Valid, Busy, Plaintext, m);
            end
        end
    endtask

    task automatic test_error;
        int m, err, lat, busy;
        run_job(200, 7, 1, m, err, lat, busy);
        checks++;
        if (busy !== 0 || lat !== 0 || err !== 1 || m !== 0) begin
            errors++;
            $display("[TB] FAIL error_n1 got busy=%0d lat=%0d err=%0d pt=%0d want 0 0 1 0", busy, lat, err, m);
        end
        @(posedge Clk);
        #1;
        checks++;
        if (Valid !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL error_pulse got valid=%0b busy=%0b want 0 0", Valid, Busy);
        end
        run_job(31, 7, 33, m, err, lat, busy);
        checks++;
        if (err !== 0 || m !== 4) begin
            errors++;
            $display("[TB] FAIL error_clear got err=%0d pt=%0d want 0 4", err, m);
        end
    endtask

    task automatic test_ignore_start;
        int lat = 0;
        Ciphertext = 8'd31;
        PrivExp    = 8'd7;
        Modulus    = 8'd33;
        Start      = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (10) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        Ciphertext = 8'd99;
        PrivExp    = 8'd200;
        Modulus    = 8'd1;
        Start      = 1'b1;
        @(posedge Clk);
        #1;
        lat++;
        Start      = 1'b0;
        Ciphertext = 8'd17;
        Modulus    = 8'd250;
        while (!Valid && lat < 400) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== model_latency(7) || Plaintext !== 8'd4 || Error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ignore_start got lat=%0d pt=%0d err=%0b want lat=%0d pt=4 err=0",
                     lat, Plaintext, Error, model_latency(7));
        end
    endtask

    task automatic test_back_to_back;
        int m, err, lat, busy;
        run_job(11, 23, 187, m, err, lat, busy);
        checks++;
        if (m !== 88) begin
            errors++;
            $display("[TB] FAIL b2b_first got %0d want 88", m);
        end
        run_job(31, 7, 33, m, err, lat, busy);
        checks++;
        if (busy !== 1 || m !== 4 || lat !== model_latency(7)) begin
            errors++;
            $display("[TB] FAIL b2b_second got busy=%0d pt=%0d lat=%0d want 1 4 %0d",
                     busy, m, lat, model_latency(7));
        end
    endtask

    task automatic test_reset_mid;
        int m, err, lat, busy;
        int pulses = 0;
        Ciphertext = 8'd11;
        PrivExp    = 8'd23;
        Modulus    = 8'd187;
        Start      = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (40) @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if ({Plaintext, Busy, Valid, Error} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid got pt=%0d busy=%0b valid=%0b err=%0b want all 0",
                     Plaintext, Busy, Valid, Error);
        end
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        repeat (150) begin
            @(posedge Clk);
            #1;
            if (Valid || Busy) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_quiet got %0d active cycles want 0", pulses);
        end
        run_job(11, 23, 187, m, err, lat, busy);
        checks++;
        if (m !== 88 || lat !== model_latency(23)) begin
            errors++;
            $display("[TB] FAIL reset_mid_recover got pt=%0d lat=%0d want 88 %0d", m, lat, model_latency(23));
        end
    endtask

    task automatic test_random;
        int m, err, lat, busy, c, d, n;
        for (int k = 0; k < 25; k++) begin
            n = int'($urandom_range(2, 255));
            c = int'($urandom_range(0, 255));
            d = int'($urandom_range(0, 255));
            run_job(c, d, n, m, err, lat, busy);
            checks++;
            if (m !== model_pow(c, d, n) || err !== 0 || lat !== model_latency(d)) begin
                errors++;
                $display("[TB] FAIL rand%0d c=%0d d=%0d n=%0d got pt=%0d err=%0d lat=%0d want pt=%0d err=0 lat=%0d",
                         k, c, d, n, m, err, lat, model_pow(c, d, n), model_latency(d));
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_error;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
